seq_instruction_decoder: RTL and testbench
==========================================

Name: seq_instruction_decoder

Overview:
- Sequenced, parametrised successor to the mini-CPU combinational decoder.
- Buffers incoming opcodes in a small FIFO and issues the registered control word (CLR, En, S) to the datapath.
- Each control word is held for a programmable number of cycles per instruction class, and a Done strobe marks completion.
- Sits between the instruction source (switches/ROM sequencer) and the register/ALU datapath.

Parameters:
- OP_WIDTH, 4, opcode width; must be ≥4. Opcodes with any bit above bit 3 set are illegal.
- BUF_DEPTH, 2, instruction FIFO depth; power of 2, ≥2.
- LOAD_CYCLES, 1, cycles the control word is held for load ops (opcodes 1–3); range 1–15.
- ALU_CYCLES, 1, cycles the control word is held for ALU ops (opcodes 4–9); range 1–15.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- InstrValid  in  1  Instruction is valid this cycle
- Instruction  in  OP_WIDTH  opcode
- InstrReady  out  1  FIFO can accept; equals !full
- CLR  out  1  clear all registers
- En  out  3  register enables {A, B, Out}
- S  out  4  S[3] = B source select; S[2:0] = ALU function
- Busy  out  1  FSM in EXEC or FIFO non-empty
- Done  out  1  one-cycle pulse on the last EXEC cycle of each instruction
- TrapClear  in  1  clears Illegal; only meaningful with the optional feature

Behaviour:
- Reset (async, active-high): FIFO emptied; FSM to IDLE; CLR=0, En=0, S=0, Done=0, Busy=0. InstrReady=1 after reset.
- Push: at a Clk edge where InstrValid && InstrReady. A push is never accepted when the FIFO is full, even if a pop occurs in the same cycle.
- Pointers: wrap modulo BUF_DEPTH. An occupancy counter distinguishes full from empty.
- FSM states: IDLE and EXEC.
  - IDLE, FIFO non-empty: pop the head, load the decoded control word into the output registers, load the hold counter, go to EXEC.
  - IDLE, FIFO empty: CLR/En/S are driven 0.
  - EXEC: outputs held constant and the counter decrements. On the last cycle Done=1.
    - If the FIFO is non-empty at that edge: pop the next entry and stay in EXEC (back-to-back, no bubble).
    - Otherwise: go to IDLE and outputs return to 0.
- Latency: an opcode pushed at edge N into an empty FIFO with the FSM idle has its outputs valid from edge N+1 through N+hold. Done is high during the last of those cycles.
- Decode, as {CLR, En, S}:
  - 0: 1_111_0000; hold is always 1 cycle.
  - 1: 0_100_0000 (load A).
  - 2: 0_010_0000 (load B, S[3]=0).
  - 3: 0_010_1000 (load B, S[3]=1).
  - 4+k for k=0..5: 0_001_0kkk (ALU function k into Out).
  - Don't-care bits are driven 0.
- Hold counts: opcodes 1–3 use LOAD_CYCLES; opcodes 4–9 use ALU_CYCLES.
- Unused/illegal opcodes (10–15, or any upper bit set):
  - Without the optional feature: a 1-cycle NOP with all outputs 0 and a Done pulse.
- Busy = (state==EXEC) || (count!=0).
- Reset mid-EXEC: outputs go to 0 immediately (asynchronously). Queued instructions are discarded.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- When defined:
  - An illegal opcode produces no Done pulse and sets a sticky output Illegal (1 bit, reset 0).
  - While Illegal=1 the FSM stays in IDLE with outputs 0 and no pops. The FIFO still accepts pushes until full.
  - TrapClear=1 at an edge clears Illegal. Issue resumes the following edge.
  - If TrapClear and a new illegal detection coincide, detection wins.
- When undefined: the Illegal port is absent, TrapClear is ignored, and illegal opcodes behave as 1-cycle NOPs.

Test Plan:
- Reset release, then push opcode 0 → at edge+1: CLR=1, En=111, S=0000 for exactly 1 cycle, with Done=1 in that cycle; then all outputs 0.
- With ALU_CYCLES=3, push opcode 6 → En=001, S=0010 held for 3 cycles, Done only on the 3rd, Busy=1 throughout.
- Push opcodes 1, 3, 9 back-to-back (BUF_DEPTH=2) →
  - InstrReady drops for 1 cycle when the FIFO is full.
  - Outputs go 0_100_0000, 0_010_1000, 0_001_0101 on consecutive cycles with no bubbles.
  - Three Done pulses.
- Push opcode 12 without the macro → 1 cycle of all-zero outputs with Done=1. With ILLEGAL_TRAP_EN → Illegal=1, no Done, a queued opcode 1 is not issued until TrapClear is pulsed, then issues next cycle.
- Assert Reset during the 2nd of 3 ALU hold cycles with one entry queued → outputs 0 immediately, Busy=0, InstrReady=1; the queued opcode never issues.
- OP_WIDTH=6, push 6'b010001 → treated as illegal (NOP or trap), not as opcode 1.

Source files
------------

// File: rtl/seq_instruction_decoder_if.sv
// Instruction/control bus of the sequenced decoder: opcode handshake in, control word out.
// The Illegal trap output only exists when ILLEGAL_TRAP_EN is defined.
interface seq_instruction_decoder_if #(
  parameter int OP_WIDTH = 4
);
  logic                instr_valid;
  logic [OP_WIDTH-1:0] instruction;
  logic                instr_ready;
  logic                clr;
  logic [2:0]          en;
  logic [3:0]          s;
  logic                busy;
  logic                done;
  logic                trap_clear;
`ifdef ILLEGAL_TRAP_EN
  logic                illegal;
`endif

  modport master (
    output instr_valid,
    output instruction,
    output trap_clear,
    input  instr_ready,
    input  clr,
    input  en,
    input  s,
    input  busy,
    input  done
`ifdef ILLEGAL_TRAP_EN
    , input illegal
`endif
  );

  modport slave (
    input  instr_valid,
    input  instruction,
    input  trap_clear,
    output instr_ready,
    output clr,
    output en,
    output s,
    output busy,
    output done
`ifdef ILLEGAL_TRAP_EN
    , output illegal
`endif
  );
endinterface

// File: rtl/seq_instruction_decoder.sv
// Sequenced instruction decoder: opcode FIFO feeding a two-state issue FSM that holds each
// registered control word {CLR, En, S} for a per-class cycle count. Optional trap: ILLEGAL_TRAP_EN.
module seq_instruction_decoder #(
  parameter int OP_WIDTH    = 4,
  parameter int BUF_DEPTH   = 2,
  parameter int LOAD_CYCLES = 1,
  parameter int ALU_CYCLES  = 1
) (
  input logic                     clk,
  input logic                     rst,
  seq_instruction_decoder_if.slave bus
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] CNT_EMPTY = CW'(0);
  localparam logic [3:0]    LOAD_HOLD = 4'(LOAD_CYCLES);
  localparam logic [3:0]    ALU_HOLD  = 4'(ALU_CYCLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  logic [OP_WIDTH-1:0] mem_r [BUF_DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [7:0]          ctrl_r;
  logic [7:0]          ctrl_nxt_s;
  logic [3:0]          hold_r;
  logic [3:0]          hold_nxt_s;
  logic                done_r;
  logic                done_nxt_s;
  logic                start_s;
  logic                can_issue_s;

  logic [OP_WIDTH-1:0] head_s;
  logic                head_legal_s;
  logic [7:0]          head_word_s;
  logic [3:0]          head_hold_s;

`ifdef ILLEGAL_TRAP_EN
  logic                illegal_r;
  logic                illegal_nxt_s;
`else
  logic                trap_clear_unused_s;
`endif

  // Upper opcode bits are tested with a shift so OP_WIDTH == 4 needs no empty slice.
  function automatic logic op_legal(input logic [OP_WIDTH-1:0] op);
    logic [OP_WIDTH-1:0] upper;
    upper = op >> 4;
    return (upper == {OP_WIDTH{1'b0}}) && (op[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] op_word(input logic [OP_WIDTH-1:0] op);
    logic [3:0] k;
    k = op[3:0] - 4'd4;
    if (!op_legal(op)) begin
      return 8'h00;
    end else begin
      case (op[3:0])
        4'd0:    return 8'b1_111_0000;
        4'd1:    return 8'b0_100_0000;
        4'd2:    return 8'b0_010_0000;
        4'd3:    return 8'b0_010_1000;
        4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                 return {5'b0_001_0, k[2:0]};
        default: return 8'h00;
      endcase
    end
  endfunction

  function automatic logic [3:0] op_hold(input logic [OP_WIDTH-1:0] op);
    if (!op_legal(op)) begin
      return 4'd1;
    end else begin
      case (op[3:0])
        4'd1, 4'd2, 4'd3:                   return LOAD_HOLD;
        4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: return ALU_HOLD;
        default:                            return 4'd1;
      endcase
    end
  endfunction

  assign full_s       = (count_r == CNT_FULL);
  assign empty_s      = (count_r == CNT_EMPTY);
  assign push_s       = bus.instr_valid && !full_s;
  assign head_s       = mem_r[rd_ptr_r];
  assign head_legal_s = op_legal(head_s);
  assign head_word_s  = op_word(head_s);
  assign head_hold_s  = op_hold(head_s);

`ifdef ILLEGAL_TRAP_EN
  assign can_issue_s  = !empty_s && !illegal_r;
`else
  assign can_issue_s  = !empty_s;
  assign trap_clear_unused_s = bus.trap_clear;
`endif

  // FIFO storage; data needs no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.instruction;
    end
  end

  // FIFO pointers and occupancy; a full FIFO refuses pushes even when popping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_EMPTY;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue FSM: next state, next control word, hold counter and Done strobe.
  always_comb begin
    state_nxt_s = state_r;
    ctrl_nxt_s  = ctrl_r;
    hold_nxt_s  = hold_r;
    done_nxt_s  = 1'b0;
    pop_s       = 1'b0;
    start_s     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_nxt_s = bus.trap_clear ? 1'b0 : illegal_r;
`endif
    case (state_r)
      IDLE: begin
        if (can_issue_s) begin
          start_s = 1'b1;
        end else begin
          ctrl_nxt_s = 8'h00;
          hold_nxt_s = 4'd0;
        end
      end
      EXEC: begin
        if (hold_r > 4'd1) begin
          hold_nxt_s = hold_r - 4'd1;
          done_nxt_s = (hold_r == 4'd2);
        end else if (can_issue_s) begin
          start_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          ctrl_nxt_s  = 8'h00;
          hold_nxt_s  = 4'd0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        ctrl_nxt_s  = 8'h00;
        hold_nxt_s  = 4'd0;
      end
    endcase

    // Popping the head either starts its hold window or, with the trap, parks the FSM.
    if (start_s) begin
      pop_s = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      if (!head_legal_s) begin
        state_nxt_s   = IDLE;
        ctrl_nxt_s    = 8'h00;
        hold_nxt_s    = 4'd0;
        done_nxt_s    = 1'b0;
        illegal_nxt_s = 1'b1;
      end else begin
        state_nxt_s = EXEC;
        ctrl_nxt_s  = head_word_s;
        hold_nxt_s  = head_hold_s;
        done_nxt_s  = (head_hold_s == 4'd1);
      end
`else
      state_nxt_s = EXEC;
      ctrl_nxt_s  = head_word_s;
      hold_nxt_s  = head_hold_s;
      done_nxt_s  = (head_hold_s == 4'd1) || !head_legal_s;
`endif
    end else begin
      pop_s = 1'b0;
    end
  end

  // FSM state and registered outputs; reset clears them asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ctrl_r  <= 8'h00;
      hold_r  <= 4'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
      hold_r  <= hold_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky trap flag; a fresh detection outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_nxt_s;
    end
  end

  assign bus.illegal = illegal_r;
`endif

  assign bus.instr_ready = !full_s;
  assign bus.clr         = ctrl_r[7];
  assign bus.en          = ctrl_r[6:4];
  assign bus.s           = ctrl_r[3:0];
  assign bus.done        = done_r;
  assign bus.busy        = (state_r == EXEC) || !empty_s;

endmodule

// File: tb/tb_seq_instruction_decoder.sv
// Self-checking bench for seq_instruction_decoder: directed steps plus random traffic
// against a queue-based reference model of the issue timeline.
module tb_seq_instruction_decoder;

  localparam int OPW   = 6;
  localparam int DEPTH = 2;
  localparam int LOADC = 2;
  localparam int ALUC  = 3;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_instruction_decoder_if #(.OP_WIDTH(OPW)) bus ();

  seq_instruction_decoder #(
    .OP_WIDTH(OPW), .BUF_DEPTH(DEPTH), .LOAD_CYCLES(LOADC), .ALU_CYCLES(ALUC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  // Reference model: pending opcodes, remaining cycles of the word on the outputs.
  logic [OPW-1:0] q[$];
  int             m_rem  = 0;
  logic [7:0]     m_word = 8'h00;
  bit             m_ill  = 1'b0;

  function automatic bit legal(input logic [OPW-1:0] op);
    return op <= 6'd9;
  endfunction

  function automatic logic [7:0] word_of(input logic [OPW-1:0] op);
    int k;
    if (!legal(op)) return 8'h00;
    if (op == 6'd0) return 8'hF0;
    if (op == 6'd1) return 8'h40;
    if (op == 6'd2) return 8'h20;
    if (op == 6'd3) return 8'h28;
    k = int'(op) - 4;
    return 8'h10 + 8'(k);
  endfunction

  function automatic int hold_of(input logic [OPW-1:0] op);
    if (!legal(op) || op == 6'd0) return 1;
    if (op <= 6'd3) return LOADC;
    return ALUC;
  endfunction

  task automatic model_reset();
    q.delete();
    m_rem  = 0;
    m_word = 8'h00;
    m_ill  = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [OPW-1:0] op, input bit tc);
    bit do_push;
    bit det;
    logic [OPW-1:0] head;
    do_push = v && (q.size() < DEPTH);
    det = 1'b0;
    if (m_rem > 1) begin
      m_rem = m_rem - 1;
    end else if (q.size() > 0 && !(TRAP && m_ill)) begin
      head = q.pop_front();
      if (TRAP && !legal(head)) begin
        det = 1'b1;
        m_rem = 0;
        m_word = 8'h00;
      end else begin
        m_rem = hold_of(head);
        m_word = word_of(head);
      end
    end else begin
      m_rem = 0;
      m_word = 8'h00;
    end
    if (TRAP) m_ill = det ? 1'b1 : (tc ? 1'b0 : m_ill);
    if (do_push) q.push_back(op);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/clr"},   32'(bus.clr),         32'(m_word[7]));
    check({tag, "/en"},    32'(bus.en),          32'(m_word[6:4]));
    check({tag, "/s"},     32'(bus.s),           32'(m_word[3:0]));
    check({tag, "/done"},  32'(bus.done),        32'(m_rem == 1));
    check({tag, "/busy"},  32'(bus.busy),        32'((m_rem > 0) || (q.size() > 0)));
    check({tag, "/ready"}, 32'(bus.instr_ready), 32'(q.size() < DEPTH));
`ifdef ILLEGAL_TRAP_EN
    check({tag, "/illegal"}, 32'(bus.illegal), 32'(m_ill));
`endif
    if (bus.done === 1'b1) done_seen++;
  endtask

  task automatic cycle(input bit v, input logic [OPW-1:0] op, input bit tc, input string tag);
    bus.instr_valid = v;
    bus.instruction = op;
    bus.trap_clear  = tc;
    @(posedge clk);
    model_edge(v, op, tc);
    #1;
    check_all(tag);
  endtask

  task automatic push_op(input logic [OPW-1:0] op, input string tag);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 8) begin
      acc = (q.size() < DEPTH);
      cycle(1'b1, op, 1'b0, tag);
      tries++;
    end
    total++;
    assert (acc) else begin
      bad++;
      $error("FAIL %s push_timeout observed=%0d expected=1", tag, acc);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'd0, 1'b0, tag);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((m_rem > 0 || q.size() > 0) && i < 40) begin
      cycle(1'b0, 6'd0, TRAP && m_ill, "drain");
      i++;
    end
  endtask

  initial begin
    int d0;
    bus.instr_valid = 1'b0;
    bus.instruction = 6'd0;
    bus.trap_clear  = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Opcode 0: clear-all word for exactly one cycle with Done.
    push_op(6'd0, "op0");
    idle(3, "op0_after");

    // ALU op held for ALU_CYCLES, Done only on the last.
    push_op(6'd6, "op6");
    idle(5, "op6_hold");

    // Back-to-back issue with the FIFO filling up.
    drain();
    d0 = done_seen;
    push_op(6'd1, "b2b1");
    push_op(6'd3, "b2b3");
    push_op(6'd9, "b2b9");
    idle(10, "b2b_run");
    check("b2b_done_count", 32'(done_seen - d0), 32'd3);

    // Illegal opcodes: out-of-range low value and an upper bit set.
    push_op(6'd12, "ill12");
    push_op(6'd1, "ill_q1");
    idle(3, "ill_wait");
    cycle(1'b0, 6'd0, 1'b1, "trapclr");
    idle(4, "ill_resume");
    drain();
    push_op(6'b010001, "ill_upper");
    idle(3, "ill_upper_after");
    drain();

    // Reset during the 2nd ALU hold cycle with one entry queued.
    push_op(6'd6, "rst_op6");
    cycle(1'b1, 6'd1, 1'b0, "rst_q1");
    cycle(1'b0, 6'd0, 1'b0, "rst_hold2");
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    #1;
    rst = 1'b0;
    idle(6, "rst_after");

    // Random traffic, mostly legal opcodes with occasional wide illegal values.
    for (int i = 0; i < 400; i++) begin
      logic [OPW-1:0] op;
      bit v;
      bit tc;
      v  = ($urandom_range(0, 2) != 0);
      op = ($urandom_range(0, 5) == 0) ? OPW'($urandom_range(0, 63)) : OPW'($urandom_range(0, 11));
      tc = ($urandom_range(0, 7) == 0);
      cycle(v, op, tc, "rand");
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
